// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte sources.
// Optional watchdog abort enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           cts,
    output logic                           utx_start,
    output logic [DATA_BITS-1:0]           utx_data,
    input  logic                           utx_busy,
    input  logic                           utx_done,
    output logic                           arb_active,
    output logic                           done_valid,
    output logic [$clog2(NUM_REQ)-1:0]     done_id,
    output logic                           err_timeout
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    logic [1:0]           state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic                 start_q, start_d;
    logic                 active_q, active_d;
    logic                 dvalid_q, dvalid_d;
    logic [IDW-1:0]       did_q, did_d;

    logic                 gnt_found;
    logic [IDW-1:0]       gnt_idx;
    logic [IDW-1:0]       gnt_next;
    logic [DATA_BITS-1:0] gnt_data;
    logic                 tmo_hit;

    // Search starts at the pointer and wraps, so the last winner goes last.
    always_comb begin
        int j;
        logic [IDW-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            idx = IDW'(j);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                gnt_data = req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign gnt_next = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        data_d   = data_q;
        ready_d  = '0;
        start_d  = 1'b0;
        active_d = active_q;
        dvalid_d = 1'b0;
        did_d    = did_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    ready_d[gnt_idx] = 1'b1;
                    data_d   = gnt_data;
                    id_d     = gnt_idx;
                    ptr_d    = gnt_next;
                    active_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (tmo_hit) begin
                    dvalid_d = 1'b1;
                    did_d    = id_q;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (cts && !utx_busy) begin
                    start_d = 1'b1;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (utx_done || tmo_hit) begin
                    dvalid_d = 1'b1;
                    did_d    = id_q;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            data_q   <= '0;
            ready_q  <= '0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
            dvalid_q <= 1'b0;
            did_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            active_q <= active_d;
            dvalid_q <= dvalid_d;
            did_q    <= did_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] wdog_q, wdog_d;
    logic           tmo_q, tmo_d;

    // Counter rests at zero in idle, so every grant starts a fresh window.
    assign wdog_d  = (state_q == S_IDLE) ? '0 : wdog_q + WDW'(1);
    assign tmo_hit = (state_q != S_IDLE) && (wdog_q == WDW'(TIMEOUT_CYCLES - 1));
    assign tmo_d   = tmo_hit && !(state_q == S_WAIT_DONE && utx_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            tmo_q  <= tmo_d;
        end
    end

    assign err_timeout = tmo_q;
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign req_ready  = ready_q;
    assign utx_start  = start_q;
    assign utx_data   = data_q;
    assign arb_active = active_q;
    assign done_valid = dvalid_q;
    assign done_id    = did_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus multi-cycle sequences.
// Timeout sequence runs only when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TMO   = 50;
    localparam int STALL = 30;
`else
    localparam int TMO   = 65535;
    localparam int STALL = 100;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        cts;
    logic        utx_start;
    logic [7:0]  utx_data;
    logic        utx_busy;
    logic        utx_done;
    logic        arb_active;
    logic        done_valid;
    logic [1:0]  done_id;
    logic        err_timeout;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_BITS(8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .cts(cts),
        .utx_start(utx_start),
        .utx_data(utx_data),
        .utx_busy(utx_busy),
        .utx_done(utx_done),
        .arb_active(arb_active),
        .done_valid(done_valid),
        .done_id(done_id),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       cts;
        logic       busy;
        logic       done;
        logic [3:0] e_ready;
        logic       e_start;
        logic [7:0] e_data;
        logic       e_active;
        logic       e_dvalid;
        logic [1:0] e_did;
    } vec_t;

    vec_t vt [18];

    int n_chk;
    int n_fail;
    int n_done;
    int n_start;
    int n_err;
    int gnt_q[$];
    int did_q[$];
    logic [7:0] sd_q[$];
    bit auto_uart;
    int ucnt;
    bit utail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Simple transmitter model: 4 busy cycles, done pulse, one more busy cycle.
    task automatic uart_tick();
        utx_done = 1'b0;
        if (utx_start) begin
            utx_busy = 1'b1;
            ucnt = 4;
        end else if (ucnt > 0) begin
            ucnt--;
            if (ucnt == 0) begin
                utx_done = 1'b1;
                utail = 1'b1;
            end
        end else if (utail) begin
            utail = 1'b0;
        end else begin
            utx_busy = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) gnt_q.push_back(i);
        end
        if (utx_start) begin
            n_start++;
            sd_q.push_back(utx_data);
        end
        if (done_valid) begin
            n_done++;
            did_q.push_back(int'(done_id));
        end
        if (err_timeout) n_err++;
        if (auto_uart) uart_tick();
    endtask

    initial begin
        int s0;
        int v;
        n_chk = 0; n_fail = 0; n_done = 0; n_start = 0; n_err = 0;
        auto_uart = 1'b0; ucnt = 0; utail = 1'b0;
        rst_n = 1'b0; req_valid = '0; req_data = 32'hC3A5113C;
        cts = 1'b1; utx_busy = 1'b0; utx_done = 1'b0;

        vt[0]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 8'hA5, 1'b1, 1'b0, 2'd0};
        vt[1]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hA5, 1'b1, 1'b0, 2'd0};
        vt[2]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b1, 1'b0, 2'd0};
        vt[3]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b1, 1'b0, 2'd0};
        vt[4]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd2};
        vt[5]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b0, 1'b0, 2'd2};
        vt[6]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b0, 1'b0, 2'd2};
        vt[7]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 8'h3C, 1'b1, 1'b0, 2'd2};
        vt[8]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h3C, 1'b1, 1'b0, 2'd2};
        vt[9]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h3C, 1'b1, 1'b0, 2'd2};
        vt[10] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h3C, 1'b1, 1'b0, 2'd2};
        vt[11] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h3C, 1'b1, 1'b0, 2'd2};
        vt[12] = '{4'b1000, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h3C, 1'b0, 1'b1, 2'd0};
        vt[13] = '{4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 8'hC3, 1'b1, 1'b0, 2'd0};
        vt[14] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hC3, 1'b1, 1'b0, 2'd0};
        vt[15] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hC3, 1'b1, 1'b0, 2'd0};
        vt[16] = '{4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 8'hC3, 1'b0, 1'b1, 2'd3};
        vt[17] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hC3, 1'b0, 1'b0, 2'd3};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_start", utx_start, 0);
        chk("rst_data", utx_data, 0);
        chk("rst_active", arb_active, 0);
        chk("rst_dvalid", done_valid, 0);
        chk("rst_did", done_id, 0);
        chk("rst_err", err_timeout, 0);
        rst_n = 1'b1;

        // single request, busy hold-off, back-to-back grant, stray done
        for (int i = 0; i < 18; i++) begin
            req_valid = vt[i].valid;
            cts = vt[i].cts;
            utx_busy = vt[i].busy;
            utx_done = vt[i].done;
            step();
            chk($sformatf("v%0d_ready", i), req_ready, vt[i].e_ready);
            chk($sformatf("v%0d_start", i), utx_start, vt[i].e_start);
            chk($sformatf("v%0d_data", i), utx_data, vt[i].e_data);
            chk($sformatf("v%0d_active", i), arb_active, vt[i].e_active);
            chk($sformatf("v%0d_dvalid", i), done_valid, vt[i].e_dvalid);
            chk($sformatf("v%0d_did", i), done_id, vt[i].e_did);
        end
        utx_done = 1'b0;
        utx_busy = 1'b0;

        // all requesters valid continuously
        gnt_q.delete(); did_q.delete(); sd_q.delete();
        n_done = 0; n_start = 0;
        req_data = 32'h44332211;
        req_valid = 4'b1111;
        auto_uart = 1'b1;
        for (int c = 0; c < 400 && n_done < 8; c++) step();
        req_valid = 4'b0000;
        repeat (4) step();
        auto_uart = 1'b0;
        utx_busy = 1'b0;
        utx_done = 1'b0;
        chk("rr_done_count", n_done, 8);
        chk("rr_start_count", n_start, 8);
        for (int i = 0; i < 8; i++) begin
            v = (i < gnt_q.size()) ? gnt_q[i] : 99;
            chk($sformatf("rr_grant%0d", i), v, i % 4);
            v = (i < did_q.size()) ? did_q[i] : 99;
            chk($sformatf("rr_did%0d", i), v, i % 4);
            v = (i < sd_q.size()) ? int'(sd_q[i]) : 999;
            chk($sformatf("rr_data%0d", i), v, 17 * ((i % 4) + 1));
        end

        // cts held low after grant
        req_valid = 4'b0010;
        cts = 1'b0;
        step();
        chk("cts_grant", req_ready, 4'b0010);
        chk("cts_data", utx_data, 8'h22);
        req_valid = 4'b0000;
        s0 = n_start;
        n_err = 0;
        repeat (STALL) step();
        chk("cts_no_start", n_start - s0, 0);
        chk("cts_active", arb_active, 1);
        chk("cts_no_timeout", n_err, 0);
        cts = 1'b1;
        step();
        chk("cts_start", utx_start, 1);
        utx_busy = 1'b1;
        step();
        utx_done = 1'b1;
        step();
        chk("cts_dvalid", done_valid, 1);
        chk("cts_did", done_id, 1);
        utx_done = 1'b0;
        utx_busy = 1'b0;
        step();

        // reset in the middle of a frame
        req_valid = 4'b0100;
        step();
        chk("mrst_grant", req_ready, 4'b0100);
        req_valid = 4'b0000;
        step();
        chk("mrst_start", utx_start, 1);
        utx_busy = 1'b1;
        step();
        chk("mrst_wait", arb_active, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_active", arb_active, 0);
        chk("mrst_data", utx_data, 0);
        chk("mrst_did", done_id, 0);
        chk("mrst_ready", req_ready, 0);
        chk("mrst_start0", utx_start, 0);
        repeat (2) @(negedge clk);
        utx_busy = 1'b0;
        rst_n = 1'b1;
        req_valid = 4'b1010;
        step();
        chk("mrst_ptr0", req_ready, 4'b0010);
        req_valid = 4'b0000;
        step();
        chk("mrst_start2", utx_start, 1);
        utx_busy = 1'b1;
        utx_done = 1'b1;
        step();
        chk("mrst_done_id", done_id, 1);
        utx_done = 1'b0;
        utx_busy = 1'b0;
        step();

`ifdef UART_TX_ARB_TIMEOUT_EN
        // watchdog: transmitter never completes
        begin
            int tc;
            logic tdv;
            logic [1:0] tid;
            tc = 0; tdv = 1'b0; tid = '0;
            req_valid = 4'b1000;
            step();
            chk("tmo_grant", req_ready, 4'b1000);
            req_valid = 4'b0000;
            for (int c = 1; c <= 60; c++) begin
                step();
                if (err_timeout && tc == 0) begin
                    tc = c;
                    tdv = done_valid;
                    tid = done_id;
                end
            end
            chk("tmo_cycle", tc, 50);
            chk("tmo_dvalid", tdv, 1);
            chk("tmo_did", tid, 3);
            chk("tmo_active", arb_active, 0);
            req_valid = 4'b0011;
            step();
            chk("tmo_next_grant", req_ready, 4'b0001);
            req_valid = 4'b0000;
            step();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
